// File: rtl/matmul_out_pkg.sv
// Shared types and arithmetic helpers for the systolic matmul output accumulator.
package matmul_out_pkg;

    localparam int unsigned AccWidthDefault = 24;
    localparam int unsigned WideW = 64;

    typedef logic signed [AccWidthDefault-1:0] acc_t;
    typedef logic signed [WideW-1:0] wide_t;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    typedef struct packed {
        logic signed [WideW-1:0] value;
        logic                    ovf;
    } sat_res_t;

    // Sign-extend the low 'width' bits of raw to the full wide_t width.
    function automatic wide_t sext(input wide_t raw, input int unsigned width);
        int unsigned sh;
        sh = WideW - width;
        return (raw <<< sh) >>> sh;
    endfunction

    // Exact add, then clamp to the signed 'width' range when sat_en; ovf flags any excursion.
    function automatic sat_res_t sat_add(input wide_t old, input wide_t addend,
                                         input int unsigned width, input logic sat_en);
        wide_t    sum;
        wide_t    max_v;
        wide_t    min_v;
        sat_res_t res;
        sum       = old + addend;
        max_v     = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        min_v     = -max_v - wide_t'(1);
        res.ovf   = (sum > max_v) || (sum < min_v);
        res.value = sum;
        if (sat_en && (sum > max_v)) begin
            res.value = max_v;
        end else if (sat_en && (sum < min_v)) begin
            res.value = min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/matmul_output_accum_hold_sampler.sv
// Per-lane sampler: phase counter over a held word, capped row counter and write strobe.
module hold_sampler #(
    parameter int unsigned HOLD = 2,
    parameter int unsigned ROWS = 4,
    localparam int unsigned PhaseW = (HOLD > 1) ? $clog2(HOLD) : 1,
    localparam int unsigned RowW = $clog2(ROWS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic            enable,
    input  logic            valid,
    output logic            write,
    output logic [RowW-1:0] row,
    output logic            complete
);

    logic [PhaseW-1:0] phase_q, phase_d;
    logic [RowW-1:0]   row_q, row_d;

    always_comb begin
        phase_d = '0;
        if (valid && (phase_q != PhaseW'(HOLD - 1))) begin
            phase_d = phase_q + 1'b1;
        end
    end

    // restart wins over a same-cycle write so an aborted pass never commits data.
    assign write = valid && (phase_q == '0) && enable && !restart &&
                   (row_q != RowW'(ROWS));

    always_comb begin
        row_d = row_q;
        if (restart) begin
            row_d = '0;
        end else if (write) begin
            row_d = row_q + 1'b1;
        end
    end

    // Complete as of the end of this cycle, so the FSM can leave COLLECT on the last write.
    assign complete = (row_q == RowW'(ROWS)) || (write && (row_q == RowW'(ROWS - 1)));
    assign row      = row_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            row_q   <= '0;
        end else begin
            phase_q <= phase_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: rtl/matmul_output_accum.sv
// Collects held systolic column outputs and proxy channel words into a ROWS x COLS accumulator.
module matmul_output_accum
    import matmul_out_pkg::*;
#(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned HOLD      = 2,
    parameter int unsigned NUM_PROXY = 1,
    parameter int unsigned SAT_EN    = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               acc_mode,
    input  logic [COLS-1:0]                    out_valid,
    input  logic [COLS*WORD_SIZE-1:0]          out_data,
    input  logic [NUM_PROXY-1:0]               proxy_en,
    input  logic [NUM_PROXY-1:0]               proxy_valid,
    input  logic [NUM_PROXY*$clog2(COLS)-1:0]  proxy_col,
    input  logic [NUM_PROXY*WORD_SIZE-1:0]     proxy_data,
    input  logic                               rd_en,
    input  logic [$clog2(ROWS)-1:0]            rd_row,
    input  logic [$clog2(COLS)-1:0]            rd_col,
    output logic [ACC_WIDTH-1:0]               rd_data,
    output logic                               rd_valid,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow
);

    localparam int unsigned ColW = $clog2(COLS);
    localparam int unsigned RowW = $clog2(ROWS + 1);

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   mat_q [ROWS][COLS];
    logic [ACC_WIDTH-1:0]   mat_d [ROWS][COLS];
    logic [NUM_PROXY-1:0]   pen_q;
    logic                   ovf_q, ovf_d;
    logic                   collect;
    logic [COLS-1:0]        arr_wr, arr_done;
    logic [RowW-1:0]        arr_row [COLS];
    logic [NUM_PROXY-1:0]   prx_wr, prx_done;
    logic [RowW-1:0]        prx_row [NUM_PROXY];
    logic                   all_done;
    logic [ACC_WIDTH-1:0]   rd_word;

    assign collect = (state_q == StCollect);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        hold_sampler #(
            .HOLD (HOLD),
            .ROWS (ROWS)
        ) u_sampler (
            .clk      (clk),
            .rst      (rst),
            .restart  (start),
            .enable   (collect),
            .valid    (out_valid[c]),
            .write    (arr_wr[c]),
            .row      (arr_row[c]),
            .complete (arr_done[c])
        );
    end

    for (genvar p = 0; p < NUM_PROXY; p++) begin : g_proxy
        hold_sampler #(
            .HOLD (HOLD),
            .ROWS (ROWS)
        ) u_sampler (
            .clk      (clk),
            .rst      (rst),
            .restart  (start),
            .enable   (collect && pen_q[p]),
            .valid    (proxy_valid[p]),
            .write    (prx_wr[p]),
            .row      (prx_row[p]),
            .complete (prx_done[p])
        );
    end

    assign all_done = (&arr_done) && (&(prx_done | ~pen_q));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    state_d = StIdle;
            StCollect: if (all_done) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (start) begin
            state_d = StCollect;
        end
    end

    // Array and proxy lanes hitting one element in the same cycle are summed before clamping.
    always_comb begin
        wide_t    addend;
        logic     hit;
        sat_res_t res;
        ovf_d  = ovf_q;
        mat_d  = mat_q;
        addend = '0;
        hit    = 1'b0;
        res    = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                addend = '0;
                hit    = 1'b0;
                res    = '0;
                if (arr_wr[c] && (arr_row[c] == RowW'(r))) begin
                    addend = addend + sext(wide_t'(out_data[c*WORD_SIZE +: WORD_SIZE]),
                                           WORD_SIZE);
                    hit    = 1'b1;
                end
                for (int p = 0; p < NUM_PROXY; p++) begin
                    if (prx_wr[p] && (prx_row[p] == RowW'(r)) &&
                        (proxy_col[p*ColW +: ColW] == ColW'(c))) begin
                        addend = addend + sext(wide_t'(proxy_data[p*WORD_SIZE +: WORD_SIZE]),
                                               WORD_SIZE);
                        hit    = 1'b1;
                    end
                end
                if (hit) begin
                    res = sat_add(sext(wide_t'(mat_q[r][c]), ACC_WIDTH), addend, ACC_WIDTH,
                                  SAT_EN != 0);
                    mat_d[r][c] = res.value[ACC_WIDTH-1:0];
                    ovf_d       = ovf_d | res.ovf;
                end
            end
        end
        if (start) begin
            ovf_d = 1'b0;
            if (!acc_mode) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        mat_d[r][c] = '0;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((int'(rd_row) == r) && (int'(rd_col) == c)) begin
                    rd_word = mat_q[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ovf_q   <= 1'b0;
            pen_q   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mat_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            mat_q   <= mat_d;
            if (start) begin
                pen_q <= proxy_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

    assign busy     = collect;
    assign done     = (state_q == StDone);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_matmul_output_accum.sv
// Directed bench: three accumulator builds share stimulus and are checked against a pass model.
module tb_matmul_output_accum;

    localparam int K     = 3;
    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int HOLDC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        acc_mode;
    logic [3:0]  out_valid;
    logic [63:0] out_data;
    logic [0:0]  proxy_en;
    logic [0:0]  proxy_valid;
    logic [1:0]  proxy_col;
    logic [15:0] proxy_data;
    logic        rd_en;
    logic [1:0]  rd_row;
    logic [1:0]  rd_col;
    logic [23:0] rd_data0;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic [2:0]  rd_valid_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  ovf_v;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    matmul_output_accum #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .ACC_WIDTH(24), .HOLD(2),
                          .NUM_PROXY(1), .SAT_EN(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .out_valid(out_valid),
        .out_data(out_data), .proxy_en(proxy_en), .proxy_valid(proxy_valid),
        .proxy_col(proxy_col), .proxy_data(proxy_data), .rd_en(rd_en), .rd_row(rd_row),
        .rd_col(rd_col), .rd_data(rd_data0), .rd_valid(rd_valid_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .overflow(ovf_v[0]));

    matmul_output_accum #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .ACC_WIDTH(16), .HOLD(2),
                          .NUM_PROXY(1), .SAT_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .out_valid(out_valid),
        .out_data(out_data), .proxy_en(proxy_en), .proxy_valid(proxy_valid),
        .proxy_col(proxy_col), .proxy_data(proxy_data), .rd_en(rd_en), .rd_row(rd_row),
        .rd_col(rd_col), .rd_data(rd_data1), .rd_valid(rd_valid_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .overflow(ovf_v[1]));

    matmul_output_accum #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .ACC_WIDTH(16), .HOLD(2),
                          .NUM_PROXY(1), .SAT_EN(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .out_valid(out_valid),
        .out_data(out_data), .proxy_en(proxy_en), .proxy_valid(proxy_valid),
        .proxy_col(proxy_col), .proxy_data(proxy_data), .rd_en(rd_en), .rd_row(rd_row),
        .rd_col(rd_col), .rd_data(rd_data2), .rd_valid(rd_valid_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .overflow(ovf_v[2]));

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- pass model ----------------
    int     aw [K] = '{24, 16, 16};
    bit     sat[K] = '{1, 1, 0};
    longint m_mat [K][NR][NC];
    bit     m_ovf [K];
    longint m_rd  [K];
    bit     m_busy, m_done, m_rv, m_pen;
    int     run_len [5];
    int     rows    [5];
    bit     lvalid  [5];
    bit     fire    [5];
    longint word    [5];
    int     lcol    [5];
    longint contrib [NR][NC];
    bit     hit     [NR][NC];
    longint s, lim;
    bit     complete_all;

    function automatic longint wrap(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < K; k++) begin
            m_ovf[k] = 0;
            m_rd[k]  = 0;
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++) m_mat[k][r][c] = 0;
        end
        for (int l = 0; l < 5; l++) begin
            run_len[l] = 0;
            rows[l]    = 0;
        end
        m_busy = 0;
        m_done = 0;
        m_rv   = 0;
        m_pen  = 0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            m_rv = rd_en;
            if (rd_en) for (int k = 0; k < K; k++) m_rd[k] = m_mat[k][rd_row][rd_col];
            for (int l = 0; l < 4; l++) begin
                lvalid[l] = out_valid[l];
                word[l]   = longint'($signed(out_data[l*16 +: 16]));
                lcol[l]   = l;
            end
            lvalid[4] = proxy_valid[0];
            word[4]   = longint'($signed(proxy_data));
            lcol[4]   = int'(proxy_col);
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++) begin
                    contrib[r][c] = 0;
                    hit[r][c]     = 0;
                end
            // A word held HOLD cycles is taken on the first cycle of each HOLD-long slot.
            for (int l = 0; l < 5; l++) begin
                fire[l] = lvalid[l] && (run_len[l] % HOLDC == 0) && m_busy && !start &&
                          (rows[l] < NR) && (l < 4 || m_pen);
                run_len[l] = lvalid[l] ? run_len[l] + 1 : 0;
                if (fire[l]) begin
                    contrib[rows[l]][lcol[l]] += word[l];
                    hit[rows[l]][lcol[l]] = 1;
                    rows[l]++;
                end
            end
            for (int k = 0; k < K; k++)
                for (int r = 0; r < NR; r++)
                    for (int c = 0; c < NC; c++)
                        if (hit[r][c]) begin
                            s   = m_mat[k][r][c] + contrib[r][c];
                            lim = longint'(1) << (aw[k] - 1);
                            if (s >= lim || s < -lim) begin
                                m_ovf[k] = 1;
                                m_mat[k][r][c] = sat[k] ? ((s >= lim) ? lim - 1 : -lim)
                                                        : wrap(s, aw[k]);
                            end else begin
                                m_mat[k][r][c] = s;
                            end
                        end
            complete_all = (rows[0] == NR) && (rows[1] == NR) && (rows[2] == NR) &&
                           (rows[3] == NR) && (!m_pen || rows[4] == NR);
            if (start) begin
                for (int l = 0; l < 5; l++) rows[l] = 0;
                for (int k = 0; k < K; k++) begin
                    m_ovf[k] = 0;
                    if (!acc_mode)
                        for (int r = 0; r < NR; r++)
                            for (int c = 0; c < NC; c++) m_mat[k][r][c] = 0;
                end
                m_pen  = proxy_en[0];
                m_busy = 1;
                m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_busy && complete_all) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < K; k++) begin
            check($sformatf("busy[%0d]", k), busy_v[k], m_busy);
            check($sformatf("done[%0d]", k), done_v[k], m_done);
            check($sformatf("overflow[%0d]", k), ovf_v[k], m_ovf[k]);
            check($sformatf("rd_valid[%0d]", k), rd_valid_v[k], m_rv);
        end
        if (m_rv) begin
            check("rd_data[0]", $signed(rd_data0), m_rd[0]);
            check("rd_data[1]", $signed(rd_data1), m_rd[1]);
            check("rd_data[2]", $signed(rd_data2), m_rd[2]);
        end
        if (done_v[0]) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    function automatic int word_of(input int mode, input int r, input int c);
        case (mode)
            1:       return (r == 0 && c == 0) ? 32760 : 0;
            2:       return (r == 0 && c == 0) ? 100 : 0;
            3:       return (r == 0 && c == 2) ? 7 : r * 4 + c + 1;
            default: return r * 4 + c + 1;
        endcase
    endfunction

    task automatic drive_cycle(input int mode, input int t, input bit use_proxy);
        for (int c = 0; c < NC; c++) begin
            int k;
            bit v;
            int d;
            k = t - c;
            v = (k >= 0 && k < NR * HOLDC);
            d = v ? word_of(mode, k / HOLDC, c) : 0;
            if (mode == 4 && c == 0) begin
                v = 1;
                case (t)
                    0, 1, 2, 3: d = 9;
                    5:          d = 3;
                    7, 8:       d = 4;
                    9, 10:      d = 50;
                    default: begin
                        v = 0;
                        d = 0;
                    end
                endcase
            end
            out_valid[c]       = v;
            out_data[c*16 +: 16] = 16'(d);
        end
        proxy_valid = 1'b0;
        proxy_data  = 16'd0;
        if (use_proxy && t >= 2 && (t - 2) / 4 < NR && (t - 2) % 4 < 2) begin
            proxy_valid = 1'b1;
            proxy_data  = ((t - 2) / 4 == 0) ? 16'd5 : 16'd1;
        end
    endtask

    task automatic run_pass(input bit acc, input int mode, input bit use_proxy,
                            input int exp_done_rel);
        done_seen = 0;
        start     = 1'b1;
        acc_mode  = acc;
        proxy_en  = use_proxy;
        proxy_col = 2'd2;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            drive_cycle(mode, t, use_proxy);
            @(negedge clk);
        end
        check("done pulses once", done_seen, 1);
        check("done cycle", done_cyc - start_cyc, exp_done_rel);
        check("busy after pass", busy_v[0], 0);
    endtask

    task automatic do_read(input int r, input int c, input string nm, input longint e0);
        rd_en  = 1'b1;
        rd_row = 2'(r);
        rd_col = 2'(c);
        @(negedge clk);
        rd_en = 1'b0;
        check({nm, " rd_valid"}, rd_valid_v[0], 1);
        check(nm, $signed(rd_data0), e0);
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        acc_mode    = 1'b0;
        out_valid   = '0;
        out_data    = '0;
        proxy_en    = '0;
        proxy_valid = '0;
        proxy_col   = '0;
        proxy_data  = '0;
        rd_en       = 1'b0;
        rd_row      = '0;
        rd_col      = '0;
        repeat (3) @(negedge clk);
        check("reset rd_data", $signed(rd_data0), 0);
        rst = 1'b1;
        @(negedge clk);

        // 1: fresh pass, matrix 1..16
        run_pass(0, 0, 0, 11);
        check("model [3][3]", m_mat[0][3][3], 16);
        do_read(0, 0, "t1 [0][0]", 1);
        do_read(2, 1, "t1 [2][1]", 10);
        do_read(3, 3, "t1 [3][3]", 16);

        // 2: accumulate the same data, every element doubles
        run_pass(1, 0, 0, 11);
        do_read(1, 2, "t2 [1][2]", 14);
        do_read(3, 3, "t2 [3][3]", 32);
        check("t2 overflow", ovf_v[0], 0);

        // 3: proxy lane into column 2 summed with the array word
        run_pass(0, 3, 1, 16);
        check("model [0][2]", m_mat[0][0][2], 12);
        do_read(0, 2, "t3 [0][2]", 12);
        do_read(1, 2, "t3 [1][2]", 8);

        // 4: 16-bit builds saturate or wrap on 32760 + 100
        run_pass(0, 1, 0, 11);
        run_pass(1, 2, 0, 11);
        do_read(0, 0, "t4 acc24 [0][0]", 32860);
        check("t4 sat16 [0][0]", $signed(rd_data1), 32767);
        check("t4 wrap16 [0][0]", $signed(rd_data2), -32676);
        check("t4 ovf acc24", ovf_v[0], 0);
        check("t4 ovf sat16", ovf_v[1], 1);
        check("t4 ovf wrap16", ovf_v[2], 1);
        check("model wrap16", m_mat[2][0][0], -32676);

        // 5: long hold, single-cycle valid, word after column completion
        run_pass(0, 4, 0, 11);
        do_read(0, 0, "t5 [0][0]", 9);
        do_read(1, 0, "t5 [1][0]", 9);
        do_read(2, 0, "t5 [2][0]", 3);
        do_read(3, 0, "t5 [3][0]", 4);

        // 6: asynchronous reset in the middle of a pass
        start    = 1'b1;
        acc_mode = 1'b0;
        proxy_en = '0;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 5; t++) begin
            drive_cycle(0, t, 0);
            @(negedge clk);
        end
        check("t6 busy before reset", busy_v[0], 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6 busy in reset", busy_v[0], 0);
        check("t6 done in reset", done_v[0], 0);
        check("t6 overflow in reset", ovf_v[0], 0);
        out_valid = '0;
        out_data  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 rd_valid idle", rd_valid_v[0], 0);
        do_read(0, 0, "t6 [0][0]", 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
